ifetch_unit: RTL and testbench

- Instruction fetch front-end. It consumes the current word-address PC from the PC register and drives the register's next-PC input.
- Issues single-outstanding requests to instruction memory and buffers returned instructions in a small FIFO.
- Hands instruction/PC pairs to decode with a valid/ready handshake.
- Handles branch/jump redirects, including discard of in-flight responses.

---
 rtl/ifetch_unit.sv | 145 ++++++++++++++
 tb/tb_ifetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: single-outstanding imem requests,
// small instruction buffer, decode handshake and redirect handling.
module ifetch_unit #(
    parameter int FIFO_DEPTH = 2,
    parameter int INSTR_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [29:0]        pc,
    output logic [29:0]        pc_next,
    output logic               imem_req,
    output logic [29:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redir_valid,
    input  logic [29:0]        redir_target,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [29:0]        id_pc,
    input  logic               id_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } state_t;

    state_t state, state_n;

    logic               outstanding, outstanding_n;
    logic [29:0]        req_pc;
    logic [INSTR_W-1:0] mem_instr [FIFO_DEPTH];
    logic [29:0]        mem_pc    [FIFO_DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic [CW-1:0]      count, count_n;
    logic [CW:0]        occ;
    logic               push, pop, gnt_req, out_keep;

    assign gnt_req   = (state == REQ) && imem_gnt;
    assign push      = (state == WAIT) && outstanding
                       && imem_rvalid && !redir_valid;
    assign id_valid  = (count != '0);
    assign pop       = id_valid && id_ready && !redir_valid;
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign id_instr  = id_valid ? mem_instr[rptr] : '0;
    assign id_pc     = id_valid ? mem_pc[rptr] : '0;
    assign occ       = {1'b0, count} + {{CW{1'b0}}, outstanding};
    assign out_keep  = outstanding && !imem_rvalid;

    always_comb begin
        pc_next = pc;
        if (redir_valid)
            pc_next = redir_target;
        else if (gnt_req)
            pc_next = pc + 30'd1;
    end

    always_comb begin
        count_n = count;
        if (redir_valid)
            count_n = '0;
        else if (push && !pop)
            count_n = count + 1'b1;
        else if (pop && !push)
            count_n = count - 1'b1;
    end

    // A redirect keeps waiting only if a response is still owed to us.
    always_comb begin
        state_n       = state;
        outstanding_n = outstanding;
        if (redir_valid) begin
            outstanding_n = out_keep || gnt_req;
            state_n       = (out_keep || gnt_req) ? DISCARD : REQ;
        end else begin
            unique case (state)
                IDLE: begin
                    if (occ < {1'b0, DEPTH})
                        state_n = REQ;
                end
                REQ: begin
                    if (imem_gnt) begin
                        outstanding_n = 1'b1;
                        state_n       = WAIT;
                    end
                end
                WAIT: begin
                    if (outstanding && imem_rvalid) begin
                        outstanding_n = 1'b0;
                        state_n = (count_n < DEPTH) ? REQ : IDLE;
                    end
                end
                DISCARD: begin
                    if (outstanding && imem_rvalid) begin
                        outstanding_n = 1'b0;
                        state_n       = REQ;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            outstanding <= 1'b0;
            req_pc      <= '0;
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
        end else begin
            state       <= state_n;
            outstanding <= outstanding_n;
            count       <= count_n;
            if (gnt_req)
                req_pc <= pc;
            if (redir_valid) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push)
                    wptr <= wptr + 1'b1;
                if (pop)
                    rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (push) begin
            mem_instr[wptr] <= imem_rdata;
            mem_pc[wptr]    <= req_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomised bench for ifetch_unit with a queue-based fetch model
// and a behavioural instruction memory responder.
module tb_ifetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b1;
    logic        reset;
    logic [29:0] pc, pc_next, imem_addr, redir_target, id_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic        redir_valid, id_valid, id_ready;
    logic [31:0] imem_rdata, id_instr;

    always #5 clk = ~clk;

    ifetch_unit #(.FIFO_DEPTH(DEPTH), .INSTR_W(32)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .redir_valid(redir_valid),
        .redir_target(redir_target), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
    );

    typedef struct packed {
        logic [31:0] i;
        logic [29:0] p;
    } ent_t;

    ent_t        q[$];
    ent_t        log_q[$];
    bit          busy, stale, req_on;
    logic [29:0] rpc, paddr;
    int          pend, gnt_pct, lat_min, lat_max, spur_en;
    int          errs = 0;
    int          checks = 0;
    bit          found;

    function automatic logic [31:0] mdata(logic [29:0] a);
        if (a < 30'd3)
            return 32'h11111111 * ({2'b00, a} + 32'd1);
        return {a, 2'b10} ^ 32'h5A5AC3C3;
    endfunction

    function automatic ent_t at(int k);
        if (k < log_q.size())
            return log_q[k];
        return '1;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        busy   = 1'b0;
        stale  = 1'b0;
        req_on = 1'b0;
    endtask

    task automatic cycle();
        ent_t        e;
        logic [29:0] epcn, opc;
        bit          g, rv, pp;
        int          n0;
        rv = (pend == 1) || (spur_en != 0 && pend == 0
             && $urandom_range(7) == 0);
        imem_rvalid = rv;
        imem_rdata  = (pend == 1) ? mdata(paddr) : $urandom;
        imem_gnt    = req_on && pend == 0
                      && ($urandom_range(99) < 32'(gnt_pct));
        #2;
        g = req_on && imem_gnt;
        if (redir_valid)
            epcn = redir_target;
        else if (g)
            epcn = pc + 30'd1;
        else
            epcn = pc;
        e = (q.size() != 0) ? q[0] : '0;
        chk("imem_req", 64'(imem_req), 64'(req_on));
        chk("imem_addr", 64'(imem_addr), 64'(pc));
        chk("pc_next", 64'(pc_next), 64'(epcn));
        chk("id_valid", 64'(id_valid), 64'(q.size() != 0));
        chk("id_instr", 64'(id_instr), 64'(e.i));
        chk("id_pc", 64'(id_pc), 64'(e.p));
        if (id_valid && id_ready && !redir_valid)
            log_q.push_back({id_instr, id_pc});
        if (redir_valid) begin
            q.delete();
            if ((busy && !rv) || g) begin
                busy = 1'b1; stale = 1'b1; req_on = 1'b0;
            end else begin
                busy = 1'b0; stale = 1'b0; req_on = 1'b1;
            end
        end else begin
            n0 = q.size();
            pp = id_ready && n0 > 0;
            if (pp)
                void'(q.pop_front());
            if (busy && rv) begin
                if (!stale) begin
                    q.push_back({imem_rdata, rpc});
                    req_on = q.size() < DEPTH;
                end else begin
                    req_on = 1'b1;
                end
                busy  = 1'b0;
                stale = 1'b0;
            end else if (g) begin
                busy   = 1'b1;
                rpc    = pc;
                req_on = 1'b0;
            end else if (!req_on && !busy && n0 < DEPTH) begin
                req_on = 1'b1;
            end
        end
        opc = pc;
        @(negedge clk);
        #1;
        pc = epcn;
        if (pend == 1)
            pend = 0;
        else if (pend > 1)
            pend--;
        if (g) begin
            pend  = $urandom_range(lat_max, lat_min);
            paddr = opc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; redir_valid = 1'b0; redir_target = '0;
        id_ready = 1'b1; pend = 0; gnt_pct = 100;
        lat_min = 1; lat_max = 1; spur_en = 0;
        model_reset();
        #12;
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_valid", 64'(id_valid), 64'(0));
        chk("rst_pcn", 64'(pc_next), 64'(0));
        chk("rst_instr", 64'(id_instr), 64'(0));
        chk("rst_pc", 64'(id_pc), 64'(0));
        @(negedge clk);
        #1;
        reset = 1'b1;

        log_q.delete();
        repeat (10) cycle();
        chk("sl_n", 64'(log_q.size() >= 3), 64'(1));
        for (int k = 0; k < 3; k++) begin
            chk("sl_instr", 64'(at(k).i), 64'(32'h11111111 * (k + 1)));
            chk("sl_pc", 64'(at(k).p), 64'(k));
        end

        id_ready = 1'b0;
        repeat (10) cycle();
        chk("bp_req", 64'(imem_req), 64'(0));
        chk("bp_valid", 64'(id_valid), 64'(1));
        chk("bp_hold", 64'(pc_next), 64'(pc));
        log_q.delete();
        id_ready = 1'b1;
        repeat (10) cycle();
        chk("bp_n", 64'(log_q.size() >= 3), 64'(1));
        for (int k = 1; k < 3; k++)
            chk("bp_order", 64'(at(k).p), 64'(at(0).p + 30'(k)));

        lat_min = 3; lat_max = 3;
        redir_valid = 1'b1; redir_target = 30'd5;
        cycle();
        redir_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (busy && !stale && rpc == 30'd5)
                found = 1'b1;
            else
                cycle();
        end
        chk("rd_gnt5", 64'(found), 64'(1));
        redir_valid = 1'b1; redir_target = 30'h100;
        cycle();
        redir_valid = 1'b0;
        chk("rd_flush", 64'(id_valid), 64'(0));
        chk("rd_addr", 64'(imem_addr), 64'(30'h100));
        log_q.delete();
        repeat (14) cycle();
        chk("rd_pc", 64'(at(0).p), 64'(30'h100));
        chk("rd_instr", 64'(at(0).i), 64'(mdata(30'h100)));

        lat_min = 1; lat_max = 1;
        redir_valid = 1'b1; redir_target = 30'h3FFFFFFF;
        cycle();
        redir_valid = 1'b0;
        log_q.delete();
        repeat (12) cycle();
        chk("wrap_pc0", 64'(at(0).p), 64'(30'h3FFFFFFF));
        chk("wrap_pc1", 64'(at(1).p), 64'(0));

        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (busy)
                found = 1'b1;
            else
                cycle();
        end
        chk("ar_busy", 64'(found), 64'(1));
        reset = 1'b0;
        #1;
        chk("ar_valid", 64'(id_valid), 64'(0));
        chk("ar_req", 64'(imem_req), 64'(0));
        model_reset();
        pc = '0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        log_q.delete();
        lat_min = 1; lat_max = 1;
        repeat (16) cycle();
        chk("ar_pc", 64'(at(0).p), 64'(0));
        chk("ar_instr", 64'(at(0).i), 64'(mdata(30'd0)));

        gnt_pct = 60; lat_min = 1; lat_max = 3; spur_en = 1;
        for (int n = 0; n < 3000; n++) begin
            id_ready    = $urandom_range(3) != 0;
            redir_valid = $urandom_range(15) == 0;
            if ($urandom_range(7) == 0)
                redir_target = 30'h3FFFFFFE + 30'($urandom_range(1));
            else
                redir_target = 30'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
